// File: rtl/rs5_plic_pkg.sv
// RS5 PLIC shared definitions: register offsets, priority width
// and the source-ID width helper.
package rs5_plic_pkg;

    localparam int PRIO_W = 3;

    localparam logic [23:0] PRIO_BASE  = 24'h000000;
    localparam logic [23:0] PEND_OFF   = 24'h001000;
    localparam logic [23:0] EN_OFF     = 24'h002000;
    localparam logic [23:0] THRESH_OFF = 24'h200000;
    localparam logic [23:0] CLAIM_OFF  = 24'h200004;

    // Bits needed to encode IDs 0..n
    function automatic int id_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rs5_plic_if.sv
// RS5 PLIC data-bus port: select, byte enables, address,
// write data and registered read data.
interface rs5_plic_if;

    logic        en_i;
    logic [3:0]  we_i;
    logic [23:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output en_i, we_i, addr_i, data_i,
        input  data_o
    );

    modport slave (
        input  en_i, we_i, addr_i, data_i,
        output data_o
    );

endinterface

// File: rtl/rs5_plic_arbiter.sv
// RS5 PLIC arbiter: highest-priority eligible source wins,
// ties resolved toward the lowest ID; 0 means none.
module rs5_plic_arbiter
    import rs5_plic_pkg::*;
#(
    parameter int i_cnt = 1,
    parameter int IDW   = id_width(i_cnt)
) (
    input  logic [i_cnt:1]             pend_i,
    input  logic [i_cnt:1]             en_i,
    input  logic [i_cnt:1][PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]          thr_i,
    output logic [IDW-1:0]             best_id_o
);

    logic [PRIO_W-1:0] best_prio;

    // Seeding with the threshold folds in "priority > threshold"
    always_comb begin
        best_prio = thr_i;
        best_id_o = '0;
        for (int k = 1; k <= i_cnt; k++) begin
            if (pend_i[k] && en_i[k] && (prio_i[k] > best_prio)) begin
                best_prio = prio_i[k];
                best_id_o = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/rs5_plic.sv
// RS5 PLIC top: gateways, register file, bus decode and
// claim/complete handling for the single machine-mode context.
module rs5_plic
    import rs5_plic_pkg::*;
#(
    parameter int i_cnt = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    rs5_plic_if.slave      bus,
    input  logic [i_cnt:1] irq_i,
    input  logic           iack_i,
    output logic [i_cnt:1] iack_o,
    output logic           irq_o
);

    localparam int IDW = id_width(i_cnt);

    logic [i_cnt:1][PRIO_W-1:0] prio_q, prio_d;
    logic [i_cnt:1]    en_q, en_d;
    logic [i_cnt:1]    pend_q, pend_d;
    logic [i_cnt:1]    insvc_q, insvc_d;
    logic [i_cnt:1]    iack_q, iack_d;
    logic [PRIO_W-1:0] thr_q, thr_d;
    logic [IDW-1:0]    claim_q, claim_d;
    logic [31:0]       data_q, data_d;
    logic              irq_q;
    logic [IDW-1:0]    best_id;

    logic        rd, wr;
    logic        hit_prio, hit_pend, hit_en, hit_thr, hit_claim;
    logic [21:0] wa;
    logic [9:0]  idx;
    logic        claim_go;
    logic        unused_addr;

    assign unused_addr = ^bus.addr_i[1:0];

    assign wa  = bus.addr_i[23:2];
    assign idx = wa[9:0];
    assign rd  = bus.en_i && (bus.we_i == 4'h0);
    assign wr  = bus.en_i && (bus.we_i != 4'h0);

    assign hit_prio  = (wa[21:10] == PRIO_BASE[23:12]);
    assign hit_pend  = (wa == PEND_OFF[23:2]);
    assign hit_en    = (wa == EN_OFF[23:2]);
    assign hit_thr   = (wa == THRESH_OFF[23:2]);
    assign hit_claim = (wa == CLAIM_OFF[23:2]);

    rs5_plic_arbiter #(
        .i_cnt (i_cnt),
        .IDW   (IDW)
    ) u_arb (
        .pend_i    (pend_q),
        .en_i      (en_q),
        .prio_i    (prio_q),
        .thr_i     (thr_q),
        .best_id_o (best_id)
    );

    // A read only claims when nothing is already held
    assign claim_go = (best_id != '0) &&
                      (iack_i || (rd && hit_claim && (claim_q == '0)));

    always_comb begin
        prio_d  = prio_q;
        en_d    = en_q;
        thr_d   = thr_q;
        insvc_d = insvc_q;
        claim_d = claim_q;
        iack_d  = '0;
        data_d  = '0;
        pend_d  = pend_q | (irq_i & ~insvc_q);

        if (wr && hit_claim) begin
            for (int k = 1; k <= i_cnt; k++) begin
                if ((bus.data_i == 32'(k)) && insvc_q[k]) begin
                    insvc_d[k] = 1'b0;
                    if (claim_q == IDW'(k)) claim_d = '0;
                end
            end
        end

        if (claim_go) begin
            claim_d = best_id;
            for (int k = 1; k <= i_cnt; k++) begin
                if (best_id == IDW'(k)) begin
                    pend_d[k]  = 1'b0;
                    insvc_d[k] = 1'b1;
                    iack_d[k]  = 1'b1;
                end
            end
        end

        if (wr) begin
            if (hit_prio) begin
                for (int k = 1; k <= i_cnt; k++) begin
                    if (idx == 10'(k)) prio_d[k] = bus.data_i[PRIO_W-1:0];
                end
            end
            if (hit_en) begin
                for (int k = 1; k <= i_cnt; k++) en_d[k] = bus.data_i[k];
            end
            if (hit_thr) thr_d = bus.data_i[PRIO_W-1:0];
        end

        if (rd) begin
            unique case (1'b1)
                hit_prio: begin
                    for (int k = 1; k <= i_cnt; k++) begin
                        if (idx == 10'(k)) data_d = 32'(prio_q[k]);
                    end
                end
                hit_pend: begin
                    for (int k = 1; k <= i_cnt; k++) data_d[k] = pend_q[k];
                end
                hit_en: begin
                    for (int k = 1; k <= i_cnt; k++) data_d[k] = en_q[k];
                end
                hit_thr:   data_d = 32'(thr_q);
                hit_claim: data_d = 32'(claim_go ? best_id : claim_q);
                default:   data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q  <= '0;
            en_q    <= '0;
            thr_q   <= '0;
            pend_q  <= '0;
            insvc_q <= '0;
            claim_q <= '0;
            iack_q  <= '0;
            data_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            en_q    <= en_d;
            thr_q   <= thr_d;
            pend_q  <= pend_d;
            insvc_q <= insvc_d;
            claim_q <= claim_d;
            iack_q  <= iack_d;
            data_q  <= data_d;
            irq_q   <= (best_id != '0);
        end
    end

    assign bus.data_o = data_q;
    assign iack_o     = iack_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_rs5_plic.sv
// Directed bench for rs5_plic with three sources: register table,
// then hand-written interrupt, completion and arbitration sequences.
module tb_rs5_plic;

    localparam int N = 3;

    localparam logic [23:0] A_P1  = 24'h000004;
    localparam logic [23:0] A_P2  = 24'h000008;
    localparam logic [23:0] A_P3  = 24'h00000C;
    localparam logic [23:0] A_PND = 24'h001000;
    localparam logic [23:0] A_EN  = 24'h002000;
    localparam logic [23:0] A_THR = 24'h200000;
    localparam logic [23:0] A_CLM = 24'h200004;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N:1]   irq_i = '0;
    logic         iack_i = 1'b0;
    logic [N:1]   iack_o;
    logic         irq_o;
    logic [31:0]  rdat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rs5_plic_if bus ();

    rs5_plic #(.i_cnt(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .irq_i   (irq_i),
        .iack_i  (iack_i),
        .iack_o  (iack_o),
        .irq_o   (irq_o)
    );

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [23:0] a, output logic [31:0] d);
        bus.en_i   = 1'b1;
        bus.we_i   = 4'h0;
        bus.addr_i = a;
        @(posedge clk);
        @(negedge clk);
        bus.en_i = 1'b0;
        d = bus.data_o;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] v);
        bus.en_i   = 1'b1;
        bus.we_i   = 4'hF;
        bus.addr_i = a;
        bus.data_i = v;
        @(posedge clk);
        @(negedge clk);
        bus.en_i = 1'b0;
        bus.we_i = 4'h0;
    endtask

    task automatic rdc(input string name, input logic [23:0] a,
                       input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.en_i   = 1'b0;
        bus.we_i   = 4'h0;
        bus.addr_i = '0;
        bus.data_i = '0;

        tbl.push_back('{1'b0, A_P1,  32'h0, 32'h0});
        tbl.push_back('{1'b0, A_P2,  32'h0, 32'h0});
        tbl.push_back('{1'b0, A_P3,  32'h0, 32'h0});
        tbl.push_back('{1'b0, A_PND, 32'h0, 32'h0});
        tbl.push_back('{1'b0, A_EN,  32'h0, 32'h0});
        tbl.push_back('{1'b0, A_THR, 32'h0, 32'h0});
        tbl.push_back('{1'b0, A_CLM, 32'h0, 32'h0});
        tbl.push_back('{1'b1, A_P1,  32'h5, 32'h0});
        tbl.push_back('{1'b0, A_P1,  32'h0, 32'h5});
        tbl.push_back('{1'b1, A_EN,  32'h2, 32'h0});
        tbl.push_back('{1'b0, A_EN,  32'h0, 32'h2});
        tbl.push_back('{1'b1, A_THR, 32'hB, 32'h0});
        tbl.push_back('{1'b0, A_THR, 32'h0, 32'h3});
        tbl.push_back('{1'b1, A_PND, 32'hE, 32'h0});
        tbl.push_back('{1'b0, A_PND, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 24'h000000, 32'h7, 32'h0});
        tbl.push_back('{1'b0, 24'h000000, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 24'h00000A, 32'hFFFFFFFE, 32'h0});
        tbl.push_back('{1'b0, A_P2,  32'h0, 32'h6});
        tbl.push_back('{1'b1, A_EN,  32'hF, 32'h0});
        tbl.push_back('{1'b0, A_EN,  32'h0, 32'hE});
        tbl.push_back('{1'b0, 24'h000010, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 24'h100000, 32'h5, 32'h0});
        tbl.push_back('{1'b0, 24'h100000, 32'h0, 32'h0});
        tbl.push_back('{1'b1, A_EN,  32'h2, 32'h0});
        tbl.push_back('{1'b1, A_P2,  32'h0, 32'h0});

        idle(3);
        check("rst_irq_o", 32'(irq_o), 32'h0);
        check("rst_iack_o", 32'(iack_o), 32'h0);
        check("rst_data_o", bus.data_o, 32'h0);
        reset_n = 1'b1;
        idle(1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else rdc($sformatf("vec%0d@%h", i, tbl[i].addr),
                     tbl[i].addr, tbl[i].exp);
        end

        // Read latency: data lands after the sampling edge, then clears
        bus.en_i   = 1'b1;
        bus.we_i   = 4'h0;
        bus.addr_i = A_P1;
        #1 check("lat_before", bus.data_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.en_i = 1'b0;
        check("lat_valid", bus.data_o, 32'h5);
        idle(1);
        check("lat_clear", bus.data_o, 32'h0);

        // Basic interrupt: prio1=5, en=0x2, thr=3
        irq_i = 3'b001;
        idle(1);
        irq_i = '0;
        check("basic_irq_1edge", 32'(irq_o), 32'h0);
        idle(1);
        check("basic_irq_2edge", 32'(irq_o), 32'h1);
        rdc("basic_pend", A_PND, 32'h2);
        iack_i = 1'b1;
        idle(1);
        iack_i = 1'b0;
        check("basic_iack", 32'(iack_o), 32'h1);
        idle(1);
        check("basic_iack_end", 32'(iack_o), 32'h0);
        check("basic_irq_drop", 32'(irq_o), 32'h0);
        rdc("basic_pend_clr", A_PND, 32'h0);
        rdc("basic_claim_rd", A_CLM, 32'h1);
        check("basic_no_pulse", 32'(iack_o), 32'h0);

        // Completion gating
        irq_i = 3'b001;
        idle(2);
        rdc("cmp_no_repend", A_PND, 32'h0);
        wr(A_CLM, 32'h7);
        wr(A_CLM, 32'h2);
        rdc("cmp_bad_ignored", A_PND, 32'h0);
        rdc("cmp_still_held", A_CLM, 32'h1);
        wr(A_CLM, 32'h1);
        rdc("cmp_pend_edge", A_PND, 32'h0);
        rdc("cmp_repend", A_PND, 32'h2);
        irq_i = '0;
        rdc("cmp_claim_read", A_CLM, 32'h1);
        check("cmp_claim_iack", 32'(iack_o), 32'h1);
        wr(A_CLM, 32'h1);

        // Threshold masking
        wr(A_P1, 32'h2);
        wr(A_THR, 32'h2);
        irq_i = 3'b001;
        idle(1);
        irq_i = '0;
        rdc("thr_pend", A_PND, 32'h2);
        idle(1);
        check("thr_masked", 32'(irq_o), 32'h0);
        wr(A_THR, 32'h1);
        check("thr_irq_lag", 32'(irq_o), 32'h0);
        idle(1);
        check("thr_unmasked", 32'(irq_o), 32'h1);
        rdc("thr_claim", A_CLM, 32'h1);
        wr(A_CLM, 32'h1);
        idle(1);
        check("thr_irq_off", 32'(irq_o), 32'h0);

        // Arbitration: priorities 4,6,6
        wr(A_P1, 32'h4);
        wr(A_P2, 32'h6);
        wr(A_P3, 32'h6);
        wr(A_EN, 32'hE);
        wr(A_THR, 32'h0);
        irq_i = 3'b111;
        idle(1);
        irq_i = '0;
        rdc("arb_pend", A_PND, 32'hE);
        rdc("arb_claim_a", A_CLM, 32'h2);
        check("arb_iack_a", 32'(iack_o), 32'h2);
        wr(A_CLM, 32'h2);
        rdc("arb_claim_b", A_CLM, 32'h3);
        check("arb_iack_b", 32'(iack_o), 32'h4);
        wr(A_CLM, 32'h3);
        rdc("arb_claim_c", A_CLM, 32'h1);
        check("arb_iack_c", 32'(iack_o), 32'h1);
        wr(A_CLM, 32'h1);
        rdc("arb_poll_none", A_CLM, 32'h0);
        check("arb_poll_iack", 32'(iack_o), 32'h0);
        check("arb_poll_irq", 32'(irq_o), 32'h0);

        // iack_i and claim read in the same cycle
        irq_i = 3'b011;
        idle(1);
        irq_i = '0;
        iack_i = 1'b1;
        rdc("dual_claim", A_CLM, 32'h2);
        iack_i = 1'b0;
        check("dual_iack", 32'(iack_o), 32'h2);
        rdc("dual_reread", A_CLM, 32'h2);
        check("dual_no_2nd", 32'(iack_o), 32'h0);
        rdc("dual_pend", A_PND, 32'h2);
        wr(A_CLM, 32'h2);
        rdc("dual_next", A_CLM, 32'h1);
        wr(A_CLM, 32'h1);

        // Reset in the middle of an acknowledge pulse
        irq_i = 3'b001;
        idle(1);
        irq_i = '0;
        idle(1);
        iack_i = 1'b1;
        idle(1);
        iack_i = 1'b0;
        check("mid_iack", 32'(iack_o), 32'h1);
        check("mid_irq", 32'(irq_o), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_iack", 32'(iack_o), 32'h0);
        check("mid_rst_irq", 32'(irq_o), 32'h0);
        idle(1);
        reset_n = 1'b1;
        idle(1);
        rdc("mid_prio", A_P1, 32'h0);
        rdc("mid_en", A_EN, 32'h0);
        rdc("mid_pend", A_PND, 32'h0);
        rdc("mid_claim", A_CLM, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs5_plic.md
Name: rs5_plic

Overview:
- Platform-level interrupt controller for the RS5 SoC, with a single machine-mode context (hart 0).
- Collects i_cnt peripheral interrupt lines and arbitrates them by priority against a threshold.
- Drives the core's external-interrupt request (mei).
- Memory-mapped on the data bus, selected when address[31:28] is 3..7; the bus passes addr[23:0] to this block.
- Hands the claimed source an acknowledge pulse when the core accepts the interrupt.

Parameters:
- i_cnt, 1, number of interrupt sources (IDs 1..i_cnt); legal range 1..31; ID 0 means "no interrupt".

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- en_i  in  1  bus access select for this block.
- we_i  in  4  byte write enables; any nonzero value performs a full 32-bit word write; 0 means read.
- addr_i  in  24  byte address within the PLIC window.
- data_i  in  32  write data.
- data_o  out  32  registered read data.
- irq_i  in  [i_cnt:1]  level interrupt requests from peripherals.
- iack_i  in  1  core accepted the external interrupt (one-cycle pulse).
- iack_o  out  [i_cnt:1]  one-hot one-cycle acknowledge to the claimed source.
- irq_o  out  1  external interrupt request to the core (mei).

Behaviour:
- Register map (word aligned; addr_i[1:0] ignored):
  - 0x000000+4*k: priority[k], k=1..i_cnt, 3 bits (bits 31:3 read 0). Word 0 reads 0 and ignores writes.
  - 0x001000: pending, bit k = source k, read-only, writes ignored.
  - 0x002000: enable, bit k = source k, RW; bit 0 is hardwired 0.
  - 0x200000: threshold, 3 bits, RW.
  - 0x200004: claim/complete. A read claims; a write completes.
- Any other address reads 0; writes to it are ignored.
- Reset: all priorities, enable, threshold, pending, in_service, claim_id, data_o, iack_o and irq_o are 0.
- Read timing: a read with en_i=1 and we_i=0 is sampled at posedge N; data_o is valid after posedge N and stays until the next posedge.
- When no read is issued, data_o is driven to 0 at the next edge.
- Writes take effect at the same posedge they are sampled.
- Gateway (per source k):
  - pending[k] is set at a posedge when irq_i[k]=1, pending[k]=0 and in_service[k]=0.
  - Once set, pending[k] clears only by a claim.
  - A source re-pends only after it has been completed.
- Arbitration (combinational):
  - Eligible means pending & enable & (priority > threshold).
  - The winner is the eligible source with the highest priority; ties go to the lowest ID.
  - best_id = 0 when nothing is eligible.
  - Priority 0 never interrupts.
- irq_o is a registered copy of (best_id != 0); it updates one cycle after pending, enable, priority or threshold change.
- Claim by iack_i at a posedge with best_id = j != 0:
  - pending[j] <= 0, in_service[j] <= 1, claim_id <= j.
  - iack_o[j] is asserted for exactly the next cycle.
  - If best_id = 0, iack_i is ignored.
- Claim by read of 0x200004:
  - If claim_id != 0, return claim_id and leave state unchanged.
  - Otherwise return best_id and perform the claim actions above, including the iack_o pulse.
  - If both are 0, return 0.
- iack_i and a claim read in the same cycle: only one claim occurs; the read returns that ID.
- Complete, by a write of j to 0x200004:
  - in_service[j] <= 0; claim_id <= 0 if claim_id == j.
  - Out-of-range values, or j that is not in service, are ignored.
- iack_o is zero except during claim pulses.
- Reset asserted mid-operation clears all state immediately, including an in-progress iack_o pulse.

Decomposition:
- Shared package: address offset constants (PRIO_BASE, PEND_OFF, EN_OFF, THRESH_OFF, CLAIM_OFF), PRIO_W=3, and the ID width function.
- One sub-module, rs5_plic_arbiter: combinational max-priority/lowest-ID selector producing best_id.
- Gateway, registers and bus decode stay in the top module.

Test Plan:
- Reset: read all registers after reset_n deasserts -> every read 0, irq_o=0, iack_o=0.
- Register RW:
  - Write priority[1]=5, enable=0x2, threshold=0x3 -> readbacks 5, 0x2, 3.
  - Data appears one cycle after the request.
  - Write to pending and read back -> 0.
- Basic interrupt:
  - With priority[1]=5, enable=0x2, threshold=0x3, pulse irq_i[1]=1 -> pending=0x2, irq_o=1 two edges later.
  - Pulse iack_i -> iack_o=0x1 for one cycle, pending=0, irq_o drops.
  - Read 0x200004 -> 1.
- Threshold masking: priority[1]=2, threshold=2, irq_i[1]=1 -> pending=0x2, irq_o stays 0. Write threshold=1 -> irq_o=1.
- Completion:
  - After a claim, hold irq_i[1]=1 -> no re-pend.
  - Write 1 to 0x200004 -> pending sets again the next cycle.
  - Write 7 (invalid) -> no effect.
- Arbitration (i_cnt=3):
  - Priorities 4,6,6 with all enabled and pending -> the claim read returns 2.
  - After complete, the next claim returns 3, then 1.
  - Polling-mode read with nothing pending -> 0, with no iack_o pulse.
